// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory access arbiter: FSM state encoding
// and memory-owner encoding used by the core_select mux.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        APB  = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    localparam logic OWN_APB  = 1'b0;
    localparam logic OWN_CORE = 1'b1;

endpackage

// File: rtl/imem_burst_counter.sv
// Grant-tenure counter: clears on ownership change, counts granted beats and
// saturates at MAX_BURST; flags the last allowed beat and the cap itself.
module imem_burst_counter #(
    parameter int MAX_BURST = 8,
    parameter int BURST_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_max,
    output logic o_at_last
);

    localparam logic [BURST_W-1:0] CNT_MAX  = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] CNT_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [BURST_W-1:0] CNT_ONE  = BURST_W'(1);

    logic [BURST_W-1:0] r_cnt;

    // Beat counter: clear wins over increment, increment stops at the cap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Flags come straight from the register so the grant path has no loop
    always_comb begin
        o_at_max  = (r_cnt == CNT_MAX);
        o_at_last = (r_cnt == CNT_LAST);
    end

endmodule

// File: rtl/imem_access_arbiter.sv
// Arbiter sharing the DFFRAM instruction memory between core and APB loader.
// Optional macro IMEM_ARB_RR_EN selects round-robin arbitration out of IDLE.
module imem_access_arbiter
    import imem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int BURST_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic boot_mode,
    input  logic core_req,
    input  logic core_rd,
    input  logic apb_req,
    input  logic apb_rd,
    output logic core_gnt,
    output logic apb_gnt,
    output logic core_rvalid,
    output logic apb_rvalid,
    output logic core_select,
    output logic core_en_gate,
    output logic apb_en_gate,
    output logic busy
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_core_ok;
    logic       w_pick_core;
    logic       w_core_gnt;
    logic       w_apb_gnt;
    logic       w_beat;
    logic       w_at_max;
    logic       w_at_last;
    logic       w_will_max;
    logic       w_last_rd;
    logic       r_last_rd;
    logic       r_turn_owner;
    logic       r_core_rvalid;
    logic       r_apb_rvalid;

    assign w_core_ok  = core_req & ~boot_mode;
    assign w_beat     = w_core_gnt | w_apb_gnt;
    // Tenure ends on the beat that brings the count to the cap
    assign w_will_max = w_at_max | (w_at_last & w_beat);

`ifdef IMEM_ARB_RR_EN
    logic r_last_owner;

    assign w_pick_core = w_core_ok & ~(apb_req & (r_last_owner == OWN_CORE));

    // Remembers which side took the most recent beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= OWN_CORE;
        end else if (w_core_gnt) begin
            r_last_owner <= OWN_CORE;
        end else if (w_apb_gnt) begin
            r_last_owner <= OWN_APB;
        end else begin
            r_last_owner <= r_last_owner;
        end
    end
`else
    assign w_pick_core = w_core_ok;
`endif

    imem_burst_counter #(
        .MAX_BURST (MAX_BURST),
        .BURST_W   (BURST_W)
    ) u_burst_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_next != r_state),
        .i_inc     (w_beat),
        .o_at_max  (w_at_max),
        .o_at_last (w_at_last)
    );

    // Per-beat grants: owner side only, withheld once capped with the other side waiting
    always_comb begin
        w_core_gnt = 1'b0;
        w_apb_gnt  = 1'b0;
        case (r_state)
            CORE: w_core_gnt = w_core_ok & ~(w_at_max & apb_req);
            APB:  w_apb_gnt  = apb_req & ~(w_at_max & w_core_ok);
            default: begin
                w_core_gnt = 1'b0;
                w_apb_gnt  = 1'b0;
            end
        endcase
    end

    // Next-state decision
    always_comb begin
        w_next    = r_state;
        w_last_rd = r_last_rd;
        case (r_state)
            IDLE: begin
                if (w_pick_core) begin
                    w_next = CORE;
                end else if (apb_req) begin
                    w_next = APB;
                end else begin
                    w_next = IDLE;
                end
            end
            CORE: begin
                w_last_rd = w_core_gnt ? core_rd : r_last_rd;
                if (!w_core_ok || (apb_req && w_will_max)) begin
                    if (w_last_rd) begin
                        w_next = TURN;
                    end else if (apb_req) begin
                        w_next = APB;
                    end else begin
                        w_next = IDLE;
                    end
                end else begin
                    w_next = CORE;
                end
            end
            APB: begin
                w_last_rd = w_apb_gnt ? apb_rd : r_last_rd;
                if (!apb_req || (w_core_ok && w_will_max)) begin
                    if (w_last_rd) begin
                        w_next = TURN;
                    end else if (w_core_ok) begin
                        w_next = CORE;
                    end else begin
                        w_next = IDLE;
                    end
                end else begin
                    w_next = APB;
                end
            end
            TURN: begin
                // The side that was waiting goes first
                if (r_turn_owner == OWN_CORE) begin
                    if (apb_req) begin
                        w_next = APB;
                    end else if (w_core_ok) begin
                        w_next = CORE;
                    end else begin
                        w_next = IDLE;
                    end
                end else begin
                    if (w_core_ok) begin
                        w_next = CORE;
                    end else if (apb_req) begin
                        w_next = APB;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, read-tracking and turnaround-owner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_rd    <= 1'b0;
            r_turn_owner <= OWN_APB;
        end else begin
            r_state      <= w_next;
            r_last_rd    <= (w_next != r_state) ? 1'b0 : w_last_rd;
            r_turn_owner <= (r_state == TURN) ? r_turn_owner :
                            ((r_state == CORE) ? OWN_CORE : OWN_APB);
        end
    end

    // Read-valid mirrors the DFFRAM's one-cycle registered read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_rvalid <= 1'b0;
            r_apb_rvalid  <= 1'b0;
        end else begin
            r_core_rvalid <= w_core_gnt & core_rd;
            r_apb_rvalid  <= w_apb_gnt & apb_rd;
        end
    end

    assign core_gnt     = w_core_gnt;
    assign apb_gnt      = w_apb_gnt;
    assign core_en_gate = w_core_gnt;
    assign apb_en_gate  = w_apb_gnt;
    assign core_rvalid  = r_core_rvalid;
    assign apb_rvalid   = r_apb_rvalid;
    assign core_select  = (r_state == CORE) |
                          ((r_state == TURN) & (r_turn_owner == OWN_CORE));
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed-vector bench for imem_access_arbiter: the driver queues the expected
// output vector for each cycle, a monitor pops and compares on the falling edge.
module tb_imem_access_arbiter;

`ifdef IMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic boot_mode = 1'b0;
    logic core_req = 1'b0;
    logic core_rd = 1'b0;
    logic apb_req = 1'b0;
    logic apb_rd = 1'b0;
    logic core_gnt, apb_gnt, core_rvalid, apb_rvalid;
    logic core_select, core_en_gate, apb_en_gate, busy;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    imem_access_arbiter #(.MAX_BURST(8), .BURST_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .boot_mode    (boot_mode),
        .core_req     (core_req),
        .core_rd      (core_rd),
        .apb_req      (apb_req),
        .apb_rd       (apb_rd),
        .core_gnt     (core_gnt),
        .apb_gnt      (apb_gnt),
        .core_rvalid  (core_rvalid),
        .apb_rvalid   (apb_rvalid),
        .core_select  (core_select),
        .core_en_gate (core_en_gate),
        .apb_en_gate  (apb_en_gate),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // e = {core_gnt, apb_gnt, core_rvalid, apb_rvalid, core_select, busy}; gates follow grants
    task automatic step(input bit r, input bit b, input bit cq, input bit cr,
                        input bit aq, input bit ar, input logic [5:0] e, input string nm);
        exp_t it;
        @(posedge clk);
        #1;
        rst       = r;
        boot_mode = b;
        core_req  = cq;
        core_rd   = cr;
        apb_req   = aq;
        apb_rd    = ar;
        it.exp    = {e[5], e[4], e[5], e[4], e[3:0]};
        it.name   = nm;
        q.push_back(it);
    endtask

    // Monitor: compares every presented output vector against the scoreboard head
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t it;
            logic [7:0] act;
            it  = q.pop_front();
            act = {core_gnt, apb_gnt, core_en_gate, apb_en_gate,
                   core_rvalid, apb_rvalid, core_select, busy};
            checks = checks + 1;
            if (act !== it.exp) begin
                failures = failures + 1;
                $display("FAIL %s: got %b expected %b (cg ag cen aen crv arv csel busy) t=%0t",
                         it.name, act, it.exp, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "reset0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "reset1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "reset_rel");

        // Boot load: APB only, core masked although requesting
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000, "boot_idle");
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010001, "boot_beat");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000001, "boot_exit");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, "boot_hold");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "boot_done");

        // Fairness: both sides writing, 8-beat alternation without gaps
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000, "fair_idle");
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b100011, "fair_core1");
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010001, "fair_apb");
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b100011, "fair_core2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, "fair_exit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "fair_idle2");

        // Core read burst of three beats, then turnaround
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, "crd_idle");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100011, "crd_b1");
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b101011, "crd_b23");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001011, "crd_exit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000011, "crd_turn");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "crd_idle2");

        // Capped core read burst with APB waiting: TURN then APB
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, "ta_idle");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b100011, "ta_b1");
        repeat (7) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b101011, "ta_bn");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b001011, "ta_turn");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b010001, "ta_apb");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, "ta_exit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "ta_idle2");

        // Simultaneous requests in IDLE, APB granted last
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000, "sim1_idle");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b100011, "sim1_first");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000011, "sim1_exit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "sim1_idle2");
        // Simultaneous requests in IDLE, core granted last
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000, "sim2_idle");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RR ? 6'b010001 : 6'b100011, "sim2_first");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RR ? 6'b000001 : 6'b000011, "sim2_exit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "sim2_idle2");

        // boot_mode rising during a core read burst
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, "br_idle");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100011, "br_beat");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001011, "br_rise");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000011, "br_turn");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, "br_masked");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "br_clear");

        // Asynchronous reset in the middle of a core read burst
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, "rm_idle");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100011, "rm_beat");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, "rm_rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "rm_rel");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, "rm_stay");

        repeat (2) @(posedge clk);
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expected vectors never compared, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
